uart_rx: RTL and testbench

UART receiver, the counterpart of uart_tx. Converts an asynchronous serial line (8N1, LSB first) into parallel bytes.
- 16x oversampling with a mid-bit 3-sample majority vote for noise rejection.
- Detects false starts, framing errors and overruns.
- Sits between the pad/loopback line and the consumer logic; holds each byte until the consumer acknowledges it.

---
 rtl/uart_rx.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, with 16x oversampling and a 2-of-3 mid-bit vote.
// Each byte is held in rx_data until the consumer acknowledges it.
// Optional parity bit: define UART_RX_PARITY_EN to add the PARITY state,
// the PARITY_ODD parameter and the parity_err output.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun_err
);

    localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int M      = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] T_SAMP0  = TICK_W'(M - 1);
    localparam logic [TICK_W-1:0] T_SAMP1  = TICK_W'(M);
    localparam logic [TICK_W-1:0] T_DECIDE = TICK_W'(M + 1);
    localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, line_prev_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        samp_q, samp_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              fe_q, fe_d;
    logic              ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              pe_q, pe_d;
`endif

    logic line, tick, maj, decide, bit_end;

    assign line    = sync2_q;
    assign tick    = (div_q == DIV_LAST);
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
    assign decide  = tick && (tick_q == T_DECIDE);
    assign bit_end = tick && (tick_q == T_LAST);

    // Two-flop synchronizer for the asynchronous line, idle-high at reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            samp_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    // Next-state logic: tick/sample bookkeeping, then per-state frame decoding.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif

        if (valid_q && rx_ack) begin
            valid_d = 1'b0;
        end

        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                tick_d = (tick_q == T_LAST) ? '0 : tick_q + TICK_W'(1);
                if (tick_q == T_SAMP0) samp_d[0] = line;
                if (tick_q == T_SAMP1) samp_d[1] = line;
            end
        end

        case (state_q)
            IDLE: begin
                div_d  = '0;
                tick_d = '0;
                if (line_prev_q && !line) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_d = maj;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    if (!maj) begin
                        fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_q != ((^shift_q) ^ PARITY_ODD)) begin
                        pe_d = 1'b1;
`endif
                    end else if (!valid_q || rx_ack) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = (state_q != IDLE);
    assign frame_err   = fe_q;
    assign overrun_err = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: fixed table of frames, hand-written corner sequences,
// then random frames against a byte-level model of the receiver.
module tb_uart_rx;

    // DIV = 6.4 MHz / (100 kbaud * 16) = 4 clocks per tick, 64 clocks per bit.
    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int TICK_CLK = CLK_FREQ / (BAUD * OS);
    localparam int BIT_CLKS = TICK_CLK * OS;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // Stop decision edge, counted in clocks from the negedge that drives the
    // start bit: 2 sync flops + 1 edge register, whole bits before the stop
    // bit, then (M+1)+1 = 10 ticks into the stop bit.
    localparam int ACK_NEG = 3 + BIT_CLKS * STOP_IDX + TICK_CLK * (OS / 2 + 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int failures = 0;
    int feCnt = 0;
    int ovCnt = 0;
    int peCnt = 0;
    int busyCycles = 0;

    bit         mValid;
    logic [7:0] mData;

    typedef struct {
        logic [7:0] data;
        bit         stopBit;
        bit         ackAfter;
        bit         expValid;
        logic [7:0] expData;
        int         expFe;
        int         expOv;
    } vec_t;
    vec_t vecs[6];

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // Count one-cycle pulses and busy cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err) feCnt++;
        if (overrun_err) ovCnt++;
        if (rx_busy) busyCycles++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) peCnt++;
`endif
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one frame onto the line, one bit every BIT_CLKS clocks.
    task automatic applyStimulus(input logic [7:0] d, input bit stopBit, input bit parFlip);
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            rx = d[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (BIT_CLKS) @(negedge clk);
        rx = (^d) ^ parFlip;
`else
        if (parFlip) $display("[TB] parity flip ignored in 8N1 build");
`endif
        repeat (BIT_CLKS) @(negedge clk);
        rx = stopBit;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    // Byte-level receiver behaviour: what one frame does to valid/data/flags.
    task automatic modelFrame(input logic [7:0] d, input bit stopBit, input bit parFlip,
                              input bit coincAck, output int fe, output int ov, output int pe);
        fe = 0; ov = 0; pe = 0;
        if (!stopBit) fe = 1;
        else if (parFlip) pe = 1;
        else if (mValid && !coincAck) ov = 1;
        else begin
            mValid = 1'b1;
            mData  = d;
        end
    endtask

    task automatic runFrame(input string name, input logic [7:0] d, input bit stopBit,
                            input bit parFlip, input bit coincAck, input bit expValid,
                            input logic [7:0] expData, input int expFe, input int expOv,
                            input int expPe);
        int fe0, ov0, pe0;
        fe0 = feCnt; ov0 = ovCnt; pe0 = peCnt;
        if (coincAck) begin
            fork
                applyStimulus(d, stopBit, parFlip);
                begin
                    @(negedge clk);
                    repeat (ACK_NEG - 1) @(negedge clk);
                    rx_ack = 1'b1;
                    @(negedge clk);
                    rx_ack = 1'b0;
                end
            join
        end else begin
            applyStimulus(d, stopBit, parFlip);
        end
        checkOutput({name, " valid"}, int'(rx_valid), int'(expValid));
        checkOutput({name, " data"}, int'(rx_data), int'(expData));
        checkOutput({name, " frame_err"}, feCnt - fe0, expFe);
        checkOutput({name, " overrun_err"}, ovCnt - ov0, expOv);
        checkOutput({name, " busy"}, int'(rx_busy), 0);
`ifdef UART_RX_PARITY_EN
        checkOutput({name, " parity_err"}, peCnt - pe0, expPe);
`else
        checkOutput({name, " no parity pulses"}, peCnt - pe0, expPe);
`endif
    endtask

    task automatic ackNow(input string name);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        mValid = 1'b0;
        checkOutput({name, " ack clears valid"}, int'(rx_valid), 0);
    endtask

    task automatic modelRun(input string name, input logic [7:0] d, input bit stopBit,
                            input bit parFlip, input bit coincAck);
        int fe, ov, pe;
        modelFrame(d, stopBit, parFlip, coincAck, fe, ov, pe);
        runFrame(name, d, stopBit, parFlip, coincAck, mValid, mData, fe, ov, pe);
    endtask

    initial begin
        int fe0, ov0, busy0;
        vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 0, 0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 0};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 0, 0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'h11, 1, 0};

        rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
        mValid = 1'b0; mData = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset data", int'(rx_data), 0);
        checkOutput("reset valid", int'(rx_valid), 0);
        checkOutput("reset busy", int'(rx_busy), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset overrun_err", int'(overrun_err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Fixed table of frames with hand-derived expectations.
        for (int i = 0; i < 6; i++) begin
            runFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stopBit, 1'b0, 1'b0,
                     vecs[i].expValid, vecs[i].expData, vecs[i].expFe, vecs[i].expOv, 0);
            mValid = vecs[i].expValid;
            mData  = vecs[i].expData;
            if (vecs[i].ackAfter) ackNow($sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Short glitch: busy rises, then drops at mid-start with no flags.
        fe0 = feCnt; ov0 = ovCnt; busy0 = busyCycles;
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (120) @(negedge clk);
        checkOutput("glitch busy seen", int'(busyCycles > busy0), 1);
        checkOutput("glitch busy dropped", int'(rx_busy), 0);
        checkOutput("glitch frame_err", feCnt - fe0, 0);
        checkOutput("glitch overrun", ovCnt - ov0, 0);
        checkOutput("glitch valid", int'(rx_valid), int'(mValid));

        // Ack landing on the completion cycle: old byte gone, new byte in, no overrun.
        modelRun("prefill44", 8'h44, 1'b1, 1'b0, 1'b0);
        modelRun("coinc33", 8'h33, 1'b1, 1'b0, 1'b1);

        // Break: one frame_err, and a line held low never retriggers.
        fe0 = feCnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        checkOutput("break busy while low", int'(rx_busy), 0);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("break frame_err", feCnt - fe0, 1);
        checkOutput("break valid kept", int'(rx_valid), int'(mValid));
        checkOutput("break data kept", int'(rx_data), int'(mData));

        // Reset during data bit 4 of 0xFF clears everything at once.
        fork
            applyStimulus(8'hFF, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (BIT_CLKS * 5 + 30) @(negedge clk);
                rst = 1'b1;
                #1;
                checkOutput("midrst valid", int'(rx_valid), 0);
                checkOutput("midrst data", int'(rx_data), 0);
                checkOutput("midrst busy", int'(rx_busy), 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        mValid = 1'b0; mData = 8'h00;
        repeat (10) @(negedge clk);
        modelRun("after reset 81", 8'h81, 1'b1, 1'b0, 1'b0);
        ackNow("after reset");

`ifdef UART_RX_PARITY_EN
        modelRun("parity good 07", 8'h07, 1'b1, 1'b0, 1'b0);
        ackNow("parity good");
        modelRun("parity bad 07", 8'h07, 1'b1, 1'b1, 1'b0);
        modelRun("parity+stop bad", 8'h07, 1'b0, 1'b1, 1'b0);
`endif

        // Random frames: data, stop quality, acks and inter-frame gaps.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            bit stopBit, parFlip, doAck;
            d       = 8'($urandom_range(0, 255));
            stopBit = ($urandom_range(0, 4) != 0);
            doAck   = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
            parFlip = ($urandom_range(0, 5) == 0);
`else
            parFlip = 1'b0;
`endif
            repeat ($urandom_range(0, 16)) @(negedge clk);
            modelRun($sformatf("rand%0d", i), d, stopBit, parFlip, 1'b0);
            if (doAck) ackNow($sformatf("rand%0d", i));
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
